// File: rtl/mips_pkg.sv
// Shared types and constants for the MEM pipeline stage: FSM states,
// access-size encodings, bus widths and lane helpers.
package mips_pkg;

    localparam int unsigned XLEN   = 32;
    localparam int unsigned REG_AW = 5;
    localparam int unsigned BE_W   = XLEN / 8;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_WAIT = 2'd2
    } mem_state_e;

    localparam logic [1:0] SZ_BYTE = 2'd0;
    localparam logic [1:0] SZ_HALF = 2'd1;
    localparam logic [1:0] SZ_WORD = 2'd2;

    typedef struct packed {
        logic            we;
        logic [XLEN-1:0] addr;
        logic [XLEN-1:0] wdata;
        logic [BE_W-1:0] be;
    } dmem_req_t;

    // Encoding 3 falls into the word branch of every helper below.
    function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] addr_lo);
        logic bad;
        case (size)
            SZ_BYTE: bad = 1'b0;
            SZ_HALF: bad = addr_lo[0];
            default: bad = (addr_lo != 2'b00);
        endcase
        return bad;
    endfunction

    function automatic logic [BE_W-1:0] lane_be(input logic [1:0] size, input logic [1:0] addr_lo);
        logic [BE_W-1:0] be;
        case (size)
            SZ_BYTE: be = 4'b0001 << addr_lo;
            SZ_HALF: be = addr_lo[1] ? 4'b1100 : 4'b0011;
            default: be = 4'b1111;
        endcase
        return be;
    endfunction

    function automatic logic [XLEN-1:0] lane_wdata(input logic [1:0] size, input logic [XLEN-1:0] data);
        logic [XLEN-1:0] wd;
        case (size)
            SZ_BYTE: wd = {4{data[7:0]}};
            SZ_HALF: wd = {2{data[15:0]}};
            default: wd = data;
        endcase
        return wd;
    endfunction

endpackage

// File: rtl/mem_load_align.sv
// Load-data lane selection and zero/sign extension (purely combinational).
module mem_load_align
    import mips_pkg::*;
(
    input  logic [XLEN-1:0] rdata,
    input  logic [1:0]      addr_lo,
    input  logic [1:0]      size,
    input  logic            sign_ext,
    output logic [XLEN-1:0] data
);

    logic [7:0]  lane_b;
    logic [15:0] lane_h;

    always_comb begin
        lane_b = rdata[7:0];
        case (addr_lo)
            2'd0:    lane_b = rdata[7:0];
            2'd1:    lane_b = rdata[15:8];
            2'd2:    lane_b = rdata[23:16];
            default: lane_b = rdata[31:24];
        endcase
        lane_h = addr_lo[1] ? rdata[31:16] : rdata[15:0];

        case (size)
            SZ_BYTE: data = {{24{sign_ext & lane_b[7]}}, lane_b};
            SZ_HALF: data = {{16{sign_ext & lane_h[15]}}, lane_h};
            default: data = rdata;
        endcase
    end

endmodule

// File: rtl/mem_stage.sv
// MEM pipeline stage: data-memory request FSM plus M->W pipeline registers.
// MEM_BYTE_LANE_EN enables byte/half accesses; otherwise every access is a word.
module mem_stage
    import mips_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic [XLEN-1:0]   ALUOutM,
    input  logic [XLEN-1:0]   WriteDataM,
    input  logic [REG_AW-1:0] WriteRegM,
    input  logic              RegWriteM,
    input  logic              MemtoRegM,
    input  logic              MemWriteM,
    input  logic [1:0]        MemSizeM,
    input  logic              MemSignedM,
    output logic              dmem_req,
    output logic              dmem_we,
    output logic [XLEN-1:0]   dmem_addr,
    output logic [XLEN-1:0]   dmem_wdata,
    output logic [BE_W-1:0]   dmem_be,
    input  logic              dmem_gnt,
    input  logic              dmem_rvalid,
    input  logic [XLEN-1:0]   dmem_rdata,
    output logic              StallM,
    output logic              AdEM,
    output logic [XLEN-1:0]   ALUOutW,
    output logic [XLEN-1:0]   ReadDataW,
    output logic [REG_AW-1:0] WriteRegW,
    output logic              RegWriteW,
    output logic              MemtoRegW
);

    mem_state_e      state, state_n;
    logic [1:0]      size_eff;
    logic            sign_eff;
    logic            mem_op;
    logic            bad_align;
    logic            req_c;
    logic            stall_c;
    logic            capture_c;
    logic            ade_c;
    logic [XLEN-1:0] load_data;
    dmem_req_t       bus;

`ifdef MEM_BYTE_LANE_EN
    assign size_eff = (MemSizeM == 2'd3) ? SZ_WORD : MemSizeM;
    assign sign_eff = MemSignedM;
`else
    logic unused_cfg;
    assign size_eff   = SZ_WORD;
    assign sign_eff   = 1'b0;
    assign unused_cfg = ^{MemSizeM, MemSignedM};
`endif

    assign mem_op    = MemtoRegM | MemWriteM;
    assign bad_align = mem_op & is_misaligned(size_eff, ALUOutM[1:0]);

    // Request fields come straight from M; upstream holds them while stalled.
    assign bus.we    = MemWriteM;
    assign bus.addr  = {ALUOutM[XLEN-1:2], 2'b00};
    assign bus.wdata = lane_wdata(size_eff, WriteDataM);
    assign bus.be    = lane_be(size_eff, ALUOutM[1:0]);

    assign dmem_req   = req_c;
    assign dmem_we    = req_c & bus.we;
    assign dmem_addr  = bus.addr;
    assign dmem_wdata = bus.wdata;
    assign dmem_be    = bus.be;
    assign StallM     = stall_c;
    assign AdEM       = ade_c;

    mem_load_align u_align (
        .rdata    (dmem_rdata),
        .addr_lo  (ALUOutM[1:0]),
        .size     (size_eff),
        .sign_ext (sign_eff),
        .data     (load_data)
    );

    always_ff @(posedge clk) begin
        if (reset) state <= S_IDLE;
        else       state <= state_n;
    end

    // Next state, request and stall; reset forces everything quiet.
    always_comb begin
        state_n   = state;
        req_c     = 1'b0;
        stall_c   = 1'b0;
        capture_c = 1'b0;
        ade_c     = 1'b0;
        case (state)
            S_IDLE: begin
                if (bad_align) begin
                    ade_c = 1'b1;
                end else if (mem_op) begin
                    req_c = 1'b1;
                    if (!dmem_gnt) begin
                        state_n = S_REQ;
                        stall_c = 1'b1;
                    end else if (!MemWriteM) begin
                        state_n = S_WAIT;
                        stall_c = 1'b1;
                    end
                end
            end
            S_REQ: begin
                req_c   = 1'b1;
                stall_c = 1'b1;
                if (dmem_gnt) begin
                    if (MemWriteM) begin
                        state_n = S_IDLE;
                        stall_c = 1'b0;
                    end else begin
                        state_n = S_WAIT;
                    end
                end
            end
            S_WAIT: begin
                stall_c = 1'b1;
                if (dmem_rvalid) begin
                    stall_c   = 1'b0;
                    capture_c = 1'b1;
                    state_n   = S_IDLE;
                end
            end
            default: state_n = S_IDLE;
        endcase
        if (reset) begin
            req_c     = 1'b0;
            stall_c   = 1'b0;
            capture_c = 1'b0;
            ade_c     = 1'b0;
        end
    end

    // W pipeline registers; a stall or address error leaves a bubble.
    always_ff @(posedge clk) begin
        if (reset) begin
            ALUOutW   <= '0;
            ReadDataW <= '0;
            WriteRegW <= '0;
            RegWriteW <= 1'b0;
            MemtoRegW <= 1'b0;
        end else begin
            if (!stall_c) begin
                ALUOutW   <= ALUOutM;
                WriteRegW <= WriteRegM;
                RegWriteW <= RegWriteM & ~ade_c;
                MemtoRegW <= MemtoRegM & ~ade_c;
            end else begin
                RegWriteW <= 1'b0;
                MemtoRegW <= 1'b0;
            end
            if (capture_c) ReadDataW <= load_data;
        end
    end

endmodule

// File: tb/tb_mem_stage.sv
// Self-checking bench for mem_stage: vector table plus multi-cycle sequences,
// with W-stage results checked through a scoreboard queue.
module tb_mem_stage;
    import mips_pkg::*;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] ALUOutM, WriteDataM, dmem_rdata;
    logic [4:0]  WriteRegM;
    logic        RegWriteM, MemtoRegM, MemWriteM, MemSignedM;
    logic [1:0]  MemSizeM;
    logic        dmem_gnt, dmem_rvalid;
    logic        dmem_req, dmem_we, StallM, AdEM;
    logic [31:0] dmem_addr, dmem_wdata, ALUOutW, ReadDataW;
    logic [3:0]  dmem_be;
    logic [4:0]  WriteRegW;
    logic        RegWriteW, MemtoRegW;

    always #5 clk = ~clk;

    mem_stage dut (
        .clk(clk), .reset(reset),
        .ALUOutM(ALUOutM), .WriteDataM(WriteDataM), .WriteRegM(WriteRegM),
        .RegWriteM(RegWriteM), .MemtoRegM(MemtoRegM), .MemWriteM(MemWriteM),
        .MemSizeM(MemSizeM), .MemSignedM(MemSignedM),
        .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
        .dmem_wdata(dmem_wdata), .dmem_be(dmem_be),
        .dmem_gnt(dmem_gnt), .dmem_rvalid(dmem_rvalid), .dmem_rdata(dmem_rdata),
        .StallM(StallM), .AdEM(AdEM),
        .ALUOutW(ALUOutW), .ReadDataW(ReadDataW), .WriteRegW(WriteRegW),
        .RegWriteW(RegWriteW), .MemtoRegW(MemtoRegW)
    );

    typedef struct {
        logic [31:0] alu, wd;
        logic [4:0]  wr;
        logic        rw, mtr, mw;
        logic [1:0]  sz;
        logic        sg, gnt, rv;
        logic [31:0] rd;
        logic        rst;
    } stim_t;

    typedef struct {
        logic        req, we, stall, ade;
        logic [31:0] addr, wdata;
        logic [3:0]  be;
        logic        cap;
        logic [31:0] rd;
    } cexp_t;

    typedef struct {
        logic [31:0] alu, rd;
        logic [4:0]  wr;
        logic        rw, mtr, live;
    } wexp_t;

    typedef struct {
        stim_t s;
        cexp_t c;
    } vec_t;

    int    n_chk  = 0;
    int    n_fail = 0;
    string tag    = "init";
    wexp_t mdl;
    wexp_t sb[$];
    vec_t  tbl[10];

    function automatic stim_t st(input logic [31:0] alu, input logic [31:0] wd, input logic [4:0] wr,
                                 input logic rw, input logic mtr, input logic mw, input logic [1:0] sz,
                                 input logic sg, input logic gnt, input logic rv, input logic [31:0] rd,
                                 input logic rst);
        stim_t s;
        s.alu = alu; s.wd = wd; s.wr = wr; s.rw = rw; s.mtr = mtr; s.mw = mw;
        s.sz = sz; s.sg = sg; s.gnt = gnt; s.rv = rv; s.rd = rd; s.rst = rst;
        return s;
    endfunction

    function automatic cexp_t ce(input logic req, input logic we, input logic stall, input logic ade,
                                 input logic [31:0] addr, input logic [31:0] wdata, input logic [3:0] be,
                                 input logic cap, input logic [31:0] rd);
        cexp_t c;
        c.req = req; c.we = we; c.stall = stall; c.ade = ade;
        c.addr = addr; c.wdata = wdata; c.be = be; c.cap = cap; c.rd = rd;
        return c;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s.%s: got %h, expected %h", tag, nm, act, exp);
        end
    endtask

    // One clock: drive at negedge, check request side, then W side after posedge.
    task automatic step(input stim_t s, input cexp_t c);
        wexp_t w;
        @(negedge clk);
        reset = s.rst; ALUOutM = s.alu; WriteDataM = s.wd; WriteRegM = s.wr;
        RegWriteM = s.rw; MemtoRegM = s.mtr; MemWriteM = s.mw; MemSizeM = s.sz;
        MemSignedM = s.sg; dmem_gnt = s.gnt; dmem_rvalid = s.rv; dmem_rdata = s.rd;
        #1;
        chk("dmem_req", 32'(dmem_req), 32'(c.req));
        chk("StallM",   32'(StallM),   32'(c.stall));
        chk("AdEM",     32'(AdEM),     32'(c.ade));
        if (c.req) begin
            chk("dmem_we",    32'(dmem_we), 32'(c.we));
            chk("dmem_addr",  dmem_addr,    c.addr);
            chk("dmem_wdata", dmem_wdata,   c.wdata);
            chk("dmem_be",    32'(dmem_be), 32'(c.be));
        end
        if (s.rst) begin
            mdl = '{alu: 32'h0, rd: 32'h0, wr: 5'h0, rw: 1'b0, mtr: 1'b0, live: 1'b1};
        end else begin
            if (!c.stall) begin
                mdl.alu = s.alu; mdl.wr = s.wr;
                mdl.rw = s.rw & ~c.ade; mdl.mtr = s.mtr & ~c.ade; mdl.live = 1'b1;
            end else begin
                mdl.rw = 1'b0; mdl.mtr = 1'b0; mdl.live = 1'b0;
            end
            if (c.cap) mdl.rd = c.rd;
        end
        sb.push_back(mdl);
        @(posedge clk);
        #1;
        w = sb.pop_front();
        chk("RegWriteW", 32'(RegWriteW), 32'(w.rw));
        chk("MemtoRegW", 32'(MemtoRegW), 32'(w.mtr));
        chk("ReadDataW", ReadDataW,      w.rd);
        if (w.live) begin
            chk("ALUOutW",   ALUOutW,         w.alu);
            chk("WriteRegW", 32'(WriteRegW),  32'(w.wr));
        end
    endtask

    localparam logic [31:0] Z = 32'h0;

    initial begin
        // Table: ops that finish in a single cycle from IDLE.
        tbl[0] = '{st(32'h1234, Z, 5'd5, 1, 0, 0, SZ_WORD, 0, 0, 0, Z, 0), ce(0, 0, 0, 0, Z, Z, 4'h0, 0, Z)};
        tbl[1] = '{st(32'hFFFFFFFF, Z, 5'd31, 1, 0, 0, SZ_WORD, 0, 0, 0, Z, 0), ce(0, 0, 0, 0, Z, Z, 4'h0, 0, Z)};
        tbl[2] = '{st(32'hABCD0003, Z, 5'd2, 0, 0, 0, SZ_WORD, 0, 1, 1, Z, 0), ce(0, 0, 0, 0, Z, Z, 4'h0, 0, Z)};
        tbl[3] = '{st(32'h200, 32'h11223344, 5'd0, 0, 0, 1, SZ_WORD, 0, 1, 0, Z, 0),
                   ce(1, 1, 0, 0, 32'h200, 32'h11223344, 4'hF, 0, Z)};
        tbl[4] = '{st(32'h206, 32'h55667788, 5'd0, 0, 0, 1, SZ_WORD, 0, 1, 0, Z, 0), ce(0, 0, 0, 1, Z, Z, 4'h0, 0, Z)};
        tbl[5] = '{st(32'h102, Z, 5'd7, 1, 1, 0, SZ_WORD, 0, 1, 0, Z, 0), ce(0, 0, 0, 1, Z, Z, 4'h0, 0, Z)};
        tbl[6] = '{st(32'h30C, 32'h9ABCDEF0, 5'd0, 0, 0, 1, 2'd3, 0, 1, 0, Z, 0),
                   ce(1, 1, 0, 0, 32'h30C, 32'h9ABCDEF0, 4'hF, 0, Z)};
`ifdef MEM_BYTE_LANE_EN
        tbl[7] = '{st(32'h201, 32'h000000AB, 5'd0, 0, 0, 1, SZ_BYTE, 0, 1, 0, Z, 0),
                   ce(1, 1, 0, 0, 32'h200, 32'hABABABAB, 4'b0010, 0, Z)};
        tbl[8] = '{st(32'h302, 32'h0000BEEF, 5'd0, 0, 0, 1, SZ_HALF, 0, 1, 0, Z, 0),
                   ce(1, 1, 0, 0, 32'h300, 32'hBEEFBEEF, 4'b1100, 0, Z)};
`else
        tbl[7] = '{st(32'h201, 32'h000000AB, 5'd0, 0, 0, 1, SZ_BYTE, 0, 1, 0, Z, 0), ce(0, 0, 0, 1, Z, Z, 4'h0, 0, Z)};
        tbl[8] = '{st(32'h302, 32'h0000BEEF, 5'd0, 0, 0, 1, SZ_HALF, 0, 1, 0, Z, 0), ce(0, 0, 0, 1, Z, Z, 4'h0, 0, Z)};
`endif
        tbl[9] = '{st(32'h301, 32'h0000BEEF, 5'd0, 0, 0, 1, SZ_HALF, 0, 1, 0, Z, 0), ce(0, 0, 0, 1, Z, Z, 4'h0, 0, Z)};

        mdl = '{alu: Z, rd: Z, wr: 5'h0, rw: 1'b0, mtr: 1'b0, live: 1'b0};

        tag = "reset";
        step(st(Z, Z, 5'd0, 0, 0, 0, SZ_WORD, 0, 0, 0, Z, 1), ce(0, 0, 0, 0, Z, Z, 4'h0, 0, Z));
        step(st(Z, Z, 5'd0, 0, 0, 0, SZ_WORD, 0, 0, 0, Z, 1), ce(0, 0, 0, 0, Z, Z, 4'h0, 0, Z));

        for (int i = 0; i < 10; i++) begin
            tag = $sformatf("row%0d", i);
            step(tbl[i].s, tbl[i].c);
        end

        tag = "ld_word_fast";
        step(st(32'h100, Z, 5'd8, 1, 1, 0, SZ_WORD, 0, 1, 0, Z, 0), ce(1, 0, 1, 0, 32'h100, Z, 4'hF, 0, Z));
        step(st(32'h100, Z, 5'd8, 1, 1, 0, SZ_WORD, 0, 0, 1, 32'hDEADBEEF, 0), ce(0, 0, 0, 0, Z, Z, 4'h0, 1, 32'hDEADBEEF));

        tag = "st_word_slow";
        step(st(32'h104, 32'hCAFEF00D, 5'd0, 0, 0, 1, SZ_WORD, 0, 0, 0, Z, 0), ce(1, 1, 1, 0, 32'h104, 32'hCAFEF00D, 4'hF, 0, Z));
        step(st(32'h104, 32'hCAFEF00D, 5'd0, 0, 0, 1, SZ_WORD, 0, 0, 1, 32'h77777777, 0), ce(1, 1, 1, 0, 32'h104, 32'hCAFEF00D, 4'hF, 0, Z));
        step(st(32'h104, 32'hCAFEF00D, 5'd0, 0, 0, 1, SZ_WORD, 0, 0, 0, Z, 0), ce(1, 1, 1, 0, 32'h104, 32'hCAFEF00D, 4'hF, 0, Z));
        step(st(32'h104, 32'hCAFEF00D, 5'd0, 0, 0, 1, SZ_WORD, 0, 1, 0, Z, 0), ce(1, 1, 0, 0, 32'h104, 32'hCAFEF00D, 4'hF, 0, Z));

        tag = "ld_word_slow";
        step(st(32'h3F0, Z, 5'd9, 1, 1, 0, SZ_WORD, 0, 0, 0, Z, 0), ce(1, 0, 1, 0, 32'h3F0, Z, 4'hF, 0, Z));
        step(st(32'h3F0, Z, 5'd9, 1, 1, 0, SZ_WORD, 0, 1, 0, Z, 0), ce(1, 0, 1, 0, 32'h3F0, Z, 4'hF, 0, Z));
        step(st(32'h3F0, Z, 5'd9, 1, 1, 0, SZ_WORD, 0, 1, 0, Z, 0), ce(0, 0, 1, 0, Z, Z, 4'h0, 0, Z));
        step(st(32'h3F0, Z, 5'd9, 1, 1, 0, SZ_WORD, 0, 0, 1, 32'h0BADF00D, 0), ce(0, 0, 0, 0, Z, Z, 4'h0, 1, 32'h0BADF00D));

`ifdef MEM_BYTE_LANE_EN
        tag = "ld_byte_signed";
        step(st(32'h203, Z, 5'd4, 1, 1, 0, SZ_BYTE, 1, 1, 0, Z, 0), ce(1, 0, 1, 0, 32'h200, Z, 4'b1000, 0, Z));
        step(st(32'h203, Z, 5'd4, 1, 1, 0, SZ_BYTE, 1, 0, 1, 32'h80000000, 0), ce(0, 0, 0, 0, Z, Z, 4'h0, 1, 32'hFFFFFF80));
        tag = "ld_byte_unsigned";
        step(st(32'h203, Z, 5'd4, 1, 1, 0, SZ_BYTE, 0, 1, 0, Z, 0), ce(1, 0, 1, 0, 32'h200, Z, 4'b1000, 0, Z));
        step(st(32'h203, Z, 5'd4, 1, 1, 0, SZ_BYTE, 0, 0, 1, 32'h80000000, 0), ce(0, 0, 0, 0, Z, Z, 4'h0, 1, 32'h00000080));
        tag = "ld_half_signed";
        step(st(32'h102, Z, 5'd6, 1, 1, 0, SZ_HALF, 1, 1, 0, Z, 0), ce(1, 0, 1, 0, 32'h100, Z, 4'b1100, 0, Z));
        step(st(32'h102, Z, 5'd6, 1, 1, 0, SZ_HALF, 1, 0, 1, 32'h80010000, 0), ce(0, 0, 0, 0, Z, Z, 4'h0, 1, 32'hFFFF8001));
`endif

        tag = "reset_in_wait";
        step(st(32'h140, Z, 5'd10, 1, 1, 0, SZ_WORD, 0, 1, 0, Z, 0), ce(1, 0, 1, 0, 32'h140, Z, 4'hF, 0, Z));
        step(st(32'h140, Z, 5'd10, 1, 1, 0, SZ_WORD, 0, 0, 0, Z, 1), ce(0, 0, 0, 0, Z, Z, 4'h0, 0, Z));
        step(st(Z, Z, 5'd0, 0, 0, 0, SZ_WORD, 0, 1, 1, 32'h55555555, 0), ce(0, 0, 0, 0, Z, Z, 4'h0, 0, Z));
        step(st(32'h180, Z, 5'd3, 1, 1, 0, SZ_WORD, 0, 1, 0, Z, 0), ce(1, 0, 1, 0, 32'h180, Z, 4'hF, 0, Z));
        step(st(32'h180, Z, 5'd3, 1, 1, 0, SZ_WORD, 0, 0, 1, 32'h12345678, 0), ce(0, 0, 0, 0, Z, Z, 4'h0, 1, 32'h12345678));

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/mem_stage.md
MEM_STAGE -- requirements
Module: mem_stage

Interface
REQ-001 clk  in  1  single clock; all state updates on rising edge.
REQ-002 reset  in  1  synchronous, active-high reset.
REQ-003 ALUOutM  in  32  address for loads/stores; result for non-memory ops.
REQ-004 WriteDataM  in  32  store data, already forwarded.
REQ-005 WriteRegM  in  5  destination register.
REQ-006 RegWriteM, MemtoRegM, MemWriteM  in  1 each  control bits of the instruction in M.
REQ-007 MemSizeM  in  2  access size: 0 = byte, 1 = half, 2 = word; 3 is illegal and treated as word.
REQ-008 MemSignedM  in  1  sign-extend sub-word loads.
REQ-009 dmem_req  out  1  memory request.
REQ-010 dmem_we  out  1  write request.
REQ-011 dmem_addr  out  32  word-aligned address, {ALUOutM[31:2], 2'b00}.
REQ-012 dmem_wdata  out  32  lane-replicated store data.
REQ-013 dmem_be  out  4  byte enables.
REQ-014 dmem_gnt  in  1  request accepted this cycle.
REQ-015 dmem_rvalid  in  1  read data valid.
REQ-016 dmem_rdata  in  32  read data.
REQ-017 StallM  out  1  M-stage op incomplete; upstream holds all M inputs stable.
REQ-018 AdEM  out  1  one-cycle misaligned-access pulse.
REQ-019 ALUOutW, ReadDataW  out  32 each  W pipeline registers.
REQ-020 WriteRegW  out  5  W pipeline register.
REQ-021 RegWriteW, MemtoRegW  out  1 each  W pipeline registers.

Function
REQ-022 FSM states are IDLE, REQ and WAIT; a memory op is MemtoRegM=1 or MemWriteM=1.
REQ-023 IDLE with an aligned memory op: assert dmem_req combinationally, with dmem_we=MemWriteM.
  - gnt=1 on a store: op completes this cycle.
  - gnt=1 on a load: go to WAIT.
  - gnt=0: go to REQ.
REQ-024 REQ: hold dmem_req and all request fields stable until gnt.
  - gnt on a store: complete, go to IDLE.
  - gnt on a load: go to WAIT.
REQ-025 WAIT: dmem_req=0; on rvalid, capture the aligned load data into ReadDataW and go to IDLE.
REQ-026 StallM = memory op present AND NOT completing this cycle; it is combinational.
REQ-027 On every clock edge where StallM=0, W registers load the M values (ALUOutW, WriteRegW, RegWriteW, MemtoRegW).
REQ-028 While StallM=1, W registers load a bubble: RegWriteW=0, MemtoRegW=0.
REQ-029 Non-memory op: zero added latency; W updates on the next edge.
REQ-030 Latency:
  - Store with immediate gnt: 1 cycle.
  - Load with immediate gnt and next-cycle rvalid: 2 cycles, 1 stall cycle.
REQ-031 Misalignment rule: word access needs addr[1:0]=0; half access needs addr[0]=0.
  - A misaligned access issues no request.
  - It pulses AdEM for one cycle with StallM=0.
  - It writes a bubble to W.
REQ-032 rvalid in IDLE or REQ is ignored; gnt is ignored outside IDLE/REQ.
REQ-033 Load data alignment: ReadDataW = selected lane, zero-extended or sign-extended per MemSignedM; a word load passes through unchanged.

Reset
REQ-034 When reset is asserted:
  - FSM goes to IDLE.
  - dmem_req=0 and AdEM=0.
  - All W registers clear to 0.
  - StallM=0 on the next cycle.
REQ-035 Reset mid-transaction abandons the access; a late rvalid/gnt after reset is ignored.

Configuration
REQ-036 Macro MEM_BYTE_LANE_EN:
  - Defined: byte and half accesses are supported; dmem_be is derived from MemSizeM and addr[1:0], with store data replicated across lanes.
  - Undefined: every access is a word access; dmem_be=4'b1111; MemSizeM and MemSignedM are ignored; only the word alignment check applies.

Structure
REQ-037 Shared package mips_pkg holds the FSM state enum, the MemSizeM encodings (SZ_BYTE/SZ_HALF/SZ_WORD) and the bus width constants.
REQ-038 One sub-module, mem_load_align, performs lane selection and extension (combinational); the FSM and W registers stay in mem_stage.

Verification
REQ-039 ALU op, ALUOutM=0x1234, RegWriteM=1, WriteRegM=5 -> next cycle ALUOutW=0x1234, WriteRegW=5, RegWriteW=1, StallM never high.
REQ-040 Load word at 0x100, gnt immediate, rvalid next cycle with 0xDEADBEEF -> StallM high for 1 cycle, then ReadDataW=0xDEADBEEF, MemtoRegW=1.
REQ-041 Store word at 0x104 with data 0xCAFEF00D, gnt held low 3 cycles -> dmem_req/addr/wdata stable for 4 cycles, StallM high for 3, dmem_be=4'b1111.
REQ-042 (MEM_BYTE_LANE_EN) signed byte load at 0x203, rdata=0x80000000 -> dmem_be=4'b1000, ReadDataW=0xFFFFFF80; unsigned -> 0x00000080.
REQ-043 Load word at 0x102 -> no dmem_req, AdEM pulse, RegWriteW=0, StallM=0.
REQ-044 Reset asserted while in WAIT, rvalid arrives the cycle after -> FSM in IDLE, ReadDataW=0, no W write.
